// File: rtl/mul_dispatch_if.sv
// Bundle of the operand, multiplier and product signals around mul_dispatch.
// Handshakes: a transfer happens on a rising clk edge where the source holds
// valid (in_valid / out_valid) and the sink holds ready (in_ready / out_ack).
// The source keeps its data stable while valid is high and not yet accepted.
// mul_start/mul_ready is a pulse/level pair: one start cycle, then mul_ready
// stays high with mul_p valid until the next start.
interface mul_dispatch_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_a;
  logic [3:0]               in_b;
  logic                     mul_start;
  logic [3:0]               mul_a;
  logic [3:0]               mul_b;
  logic                     mul_ready;
  logic [7:0]               mul_p;
  logic                     out_valid;
  logic                     out_ack;
  logic [7:0]               out_p;
  logic [$clog2(DEPTH):0]   count;
  logic                     busy;
  logic                     err;
  logic [1:0]               dbg_state;

  // Dispatcher side
  modport slave (
    input  in_valid, in_a, in_b, mul_ready, mul_p, out_ack,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_p,
           count, busy, err, dbg_state
  );

  // Producer / multiplier / consumer side
  modport master (
    output in_valid, in_a, in_b, mul_ready, mul_p, out_ack,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_p,
           count, busy, err, dbg_state
  );
endinterface

// File: rtl/mul_dispatch.sv
// Operand dispatcher for the 4-bit signed add-shift multiplier.
// Operand pairs are queued in a small FIFO, issued one at a time with a
// single-cycle start pulse, and each 8-bit product is held in an output
// register under a valid/ack handshake. A watchdog drops operations whose
// multiplier never reports done and sets a sticky error flag.
module mul_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mul_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_tmo;
  logic            r_mul_start;
  logic [3:0]      r_mul_a;
  logic [3:0]      r_mul_b;
  logic            r_out_valid;
  logic [7:0]      r_out_p;
  logic            r_err;

  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_ready_q;
  logic            w_capture;
  logic            w_timeout;

  // r_tmo is zero only in the first WAIT cycle, where a stale done level
  // left over from the previous operation must be ignored.
  assign w_in_ready = reset & (r_count != CW'(DEPTH));
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_ready_q  = bus.mul_ready && (r_tmo != '0);
  assign w_capture  = (r_state == S_WAIT) && w_ready_q &&
                      (!r_out_valid || bus.out_ack);
  assign w_timeout  = (r_state == S_WAIT) && !w_ready_q &&
                      (r_tmo == TW'(TIMEOUT));

  // FIFO storage: written on push, no reset needed for the data array.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {bus.in_a, bus.in_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM with registered multiplier and output-side signals.
  // While a finished product is blocked by an unacknowledged output the
  // watchdog is frozen: the multiplier is done, it is the consumer that stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      if (r_out_valid && bus.out_ack) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_mul_a, r_mul_b} <= r_mem[r_rd];
            r_mul_start        <= 1'b1;
            r_state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_capture) begin
            r_out_p     <= bus.mul_p;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (!w_ready_q) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mul_start = r_mul_start;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_p     = r_out_p;
  assign bus.count     = r_count;
  assign bus.busy      = (r_state != S_IDLE) || (r_count != '0);
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;
endmodule
